pipeline_stage_buf: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline latches. It is a generic stage register with a payload width parameter and a valid/ready handshake on both sides. It has a 2-entry skid buffer, so in_ready is driven from flops only, plus stall, flush and halt-lock control. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the packed control and data fields carried as one payload word.

---
 rtl/pipeline_stage_buf.sv | 148 ++++++++++++++
 tb/tb_pipeline_stage_buf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_buf.sv
// ---------------------------------------------------------------------------
// pipeline_stage_buf
//
// Generic inter-stage pipeline register with a valid/ready handshake on both
// sides. Two storage entries: head H (drives the outputs) and skid S (catches
// a word accepted while the head is blocked). The skid lets in_ready come
// straight from flops. Stall freezes the stage. Flush empties it. A halt
// word leaving the stage sets a sticky lock that stops further accepts.
//
// Parameters:
//   DATA_W    payload width in bits (>= 1)
//   NOP_VALUE value driven on out_data while out_valid = 0
//   SKID_EN   1: two entries, in_ready from flops only
//             0: single entry, in_ready also depends on out_ready
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   stage can accept a word this cycle
//   in_data    upstream payload
//   in_halt    upstream word is a halt marker
//   stall      freeze: no accept, no emit, state held
//   flush      drop all held words and any incoming word
//   out_valid  head entry valid
//   out_ready  downstream accepts the head
//   out_data   head payload, NOP_VALUE when empty
//   out_halt   head halt flag, 0 when empty
//   halt_lock  sticky: a halt word has left the stage
//   occupancy  number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipeline_stage_buf #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halt_lock,
  output logic [1:0]        occupancy
);

  logic              h_valid_q, h_valid_d;
  logic [DATA_W-1:0] h_data_q,  h_data_d;
  logic              h_halt_q,  h_halt_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              s_halt_q,  s_halt_d;
  logic              halt_lock_q, halt_lock_d;

  logic accept;
  logic emit;

  // in_ready also drops while RST is high, so it is combinational in RST.
  generate
    if (SKID_EN) begin : g_skid
      // Flop-only path: a free skid slot always absorbs one more word.
      assign in_ready = ~s_valid_q & ~halt_lock_q & ~RST;
    end else begin : g_single
      // Single entry: accept only if the head is empty or leaving.
      assign in_ready = (~h_valid_q | out_ready) & ~halt_lock_q & ~RST;
    end
  endgenerate

  assign accept = in_valid  & in_ready  & ~stall & ~flush;
  assign emit   = out_valid & out_ready & ~stall & ~flush;

  always_comb begin
    h_valid_d   = h_valid_q;
    h_data_d    = h_data_q;
    h_halt_d    = h_halt_q;
    s_valid_d   = s_valid_q;
    s_data_d    = s_data_q;
    s_halt_d    = s_halt_q;
    // emit already excludes stall and flush, so a flushed halt never locks.
    halt_lock_d = halt_lock_q | (emit & h_halt_q);

    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!stall) begin
      if (emit && accept) begin
        if (s_valid_q) begin
          // Keep FIFO order: skid moves up, new word takes the skid slot.
          h_data_d  = s_data_q;
          h_halt_d  = s_halt_q;
          s_data_d  = in_data;
          s_halt_d  = in_halt;
        end else begin
          h_data_d  = in_data;
          h_halt_d  = in_halt;
        end
      end else if (emit) begin
        h_valid_d = s_valid_q;
        h_data_d  = s_data_q;
        h_halt_d  = s_halt_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        if (!h_valid_q) begin
          h_valid_d = 1'b1;
          h_data_d  = in_data;
          h_halt_d  = in_halt;
        end else if (SKID_EN) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
          s_halt_d  = in_halt;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_valid_q   <= 1'b0;
      h_data_q    <= NOP_VALUE;
      h_halt_q    <= 1'b0;
      s_valid_q   <= 1'b0;
      s_data_q    <= NOP_VALUE;
      s_halt_q    <= 1'b0;
      halt_lock_q <= 1'b0;
    end else begin
      h_valid_q   <= h_valid_d;
      h_data_q    <= h_data_d;
      h_halt_q    <= h_halt_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_halt_q    <= s_halt_d;
      halt_lock_q <= halt_lock_d;
    end
  end

  assign out_valid = h_valid_q;
  assign out_data  = h_valid_q ? h_data_q : NOP_VALUE;
  assign out_halt  = h_valid_q & h_halt_q;
  assign halt_lock = halt_lock_q;
  assign occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipeline_stage_buf.sv
module tb_pipeline_stage_buf;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_halt;
  logic        stall;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_halt,  halt_lock;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        in_ready_0, out_valid_0, out_halt_0, halt_lock_0;
  logic [31:0] out_data_0;
  logic [1:0]  occupancy_0;

  int checks = 0;
  int errors = 0;

  pipeline_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .halt_lock(halt_lock), .occupancy(occupancy)
  );

  pipeline_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID_EN(1'b0)) dut0 (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready_0), .in_data(in_data), .in_halt(in_halt),
    .stall(stall), .flush(flush),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0), .out_halt(out_halt_0),
    .halt_lock(halt_lock_0), .occupancy(occupancy_0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        h;
    logic        st;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_oh;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic        e_hl;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(logic iv, logic [31:0] d, logic h, logic st, logic fl, logic ordy,
                              logic e_ov, logic [31:0] e_od, logic e_oh, logic e_ir,
                              logic [1:0] e_occ, logic e_hl);
    vec_t v;
    v.iv = iv; v.d = d; v.h = h; v.st = st; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_oh = e_oh; v.e_ir = e_ir; v.e_occ = e_occ; v.e_hl = e_hl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic h,
                       input logic st, input logic fl, input logic ordy);
    in_valid = iv; in_data = d; in_halt = h; stall = st; flush = fl; out_ready = ordy;
  endtask

  task automatic run_vec(input int i);
    @(negedge CLK);
    drive(vt[i].iv, vt[i].d, vt[i].h, vt[i].st, vt[i].fl, vt[i].ordy);
    @(posedge CLK);
    #1;
    $display("vec %0d: iv=%0b d=0x%0h h=%0b st=%0b fl=%0b ordy=%0b -> ov=%0b od=0x%0h oh=%0b ir=%0b occ=%0d hl=%0b",
             i, vt[i].iv, vt[i].d, vt[i].h, vt[i].st, vt[i].fl, vt[i].ordy,
             out_valid, out_data, out_halt, in_ready, occupancy, halt_lock);
    check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_ov});
    check($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
    check($sformatf("v%0d_out_halt", i), {31'b0, out_halt}, {31'b0, vt[i].e_oh});
    check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].e_ir});
    check($sformatf("v%0d_occupancy", i), {30'b0, occupancy}, {30'b0, vt[i].e_occ});
    check($sformatf("v%0d_halt_lock", i), {31'b0, halt_lock}, {31'b0, vt[i].e_hl});
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    drive(0, 32'h0, 0, 0, 0, 0);
    #2 RST = 1'b1;
    #1;
    $display("async reset asserted mid-cycle: ov=%0b occ=%0d hl=%0b ir=%0b", out_valid, occupancy, halt_lock, in_ready);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_occupancy", {30'b0, occupancy}, 32'd0);
    check("rst_halt_lock", {31'b0, halt_lock}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    $display("reset released: ir=%0b", in_ready);
    check("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    // Streaming
    vt[0]  = mk(1, 32'h1, 0, 0, 0, 1,  1, 32'h1, 0, 1, 1, 0);
    vt[1]  = mk(1, 32'h2, 0, 0, 0, 1,  1, 32'h2, 0, 1, 1, 0);
    vt[2]  = mk(1, 32'h3, 0, 0, 0, 1,  1, 32'h3, 0, 1, 1, 0);
    vt[3]  = mk(0, 32'h0, 0, 0, 0, 1,  0, 32'h0, 0, 1, 0, 0);
    // Backpressure and skid; 0xC held upstream while in_ready=0
    vt[4]  = mk(1, 32'hA, 0, 0, 0, 0,  1, 32'hA, 0, 1, 1, 0);
    vt[5]  = mk(1, 32'hB, 0, 0, 0, 0,  1, 32'hA, 0, 0, 2, 0);
    vt[6]  = mk(1, 32'hC, 0, 0, 0, 0,  1, 32'hA, 0, 0, 2, 0);
    vt[7]  = mk(1, 32'hC, 0, 0, 0, 1,  1, 32'hB, 0, 1, 1, 0);
    vt[8]  = mk(1, 32'hC, 0, 0, 0, 1,  1, 32'hC, 0, 1, 1, 0);
    vt[9]  = mk(0, 32'h0, 0, 0, 0, 1,  0, 32'h0, 0, 1, 0, 0);
    // Stall then flush overriding stall
    vt[10] = mk(1, 32'hD, 0, 0, 0, 0,  1, 32'hD, 0, 1, 1, 0);
    vt[11] = mk(1, 32'hE, 0, 0, 0, 0,  1, 32'hD, 0, 0, 2, 0);
    vt[12] = mk(1, 32'hF, 0, 1, 0, 1,  1, 32'hD, 0, 0, 2, 0);
    vt[13] = mk(1, 32'hF, 0, 1, 0, 1,  1, 32'hD, 0, 0, 2, 0);
    vt[14] = mk(1, 32'hF, 0, 1, 0, 1,  1, 32'hD, 0, 0, 2, 0);
    vt[15] = mk(1, 32'hF, 0, 1, 1, 1,  0, 32'h0, 0, 1, 0, 0);
    // Halt: 0x5, 0x6(halt), then 0x7 offered after the lock
    vt[16] = mk(1, 32'h5, 0, 0, 0, 0,  1, 32'h5, 0, 1, 1, 0);
    vt[17] = mk(1, 32'h6, 1, 0, 0, 0,  1, 32'h5, 0, 0, 2, 0);
    vt[18] = mk(1, 32'h7, 0, 0, 0, 0,  1, 32'h5, 0, 0, 2, 0);
    vt[19] = mk(1, 32'h7, 0, 0, 0, 1,  1, 32'h6, 1, 1, 1, 0);
    vt[20] = mk(0, 32'h7, 0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 1);
    vt[21] = mk(1, 32'h7, 0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 1);
    vt[22] = mk(1, 32'h7, 0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 1);
    vt[23] = mk(1, 32'h7, 0, 0, 1, 1,  0, 32'h0, 0, 0, 0, 1);
    // Flushed halt word does not lock (run after a reset pulse)
    vt[24] = mk(1, 32'h9, 1, 0, 0, 0,  1, 32'h9, 1, 1, 1, 0);
    vt[25] = mk(0, 32'h0, 0, 0, 1, 0,  0, 32'h0, 0, 1, 0, 0);
    vt[26] = mk(0, 32'h0, 0, 0, 0, 1,  0, 32'h0, 0, 1, 0, 0);

    RST = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    $display("in reset: ov=%0b occ=%0d hl=%0b ir=%0b od=0x%0h", out_valid, occupancy, halt_lock, in_ready, out_data);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_occupancy", {30'b0, occupancy}, 32'd0);
    check("reset_halt_lock", {31'b0, halt_lock}, 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_halt", {31'b0, out_halt}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 24; i++) run_vec(i);

    // Lock is set here; an async reset must clear it before any edge.
    reset_pulse();

    for (int i = 24; i < NV; i++) run_vec(i);

    // Async reset with both entries full.
    @(negedge CLK); drive(1, 32'h21, 0, 0, 0, 0);
    @(negedge CLK); drive(1, 32'h22, 0, 0, 0, 0);
    @(posedge CLK); #1;
    $display("pre-reset fill: occ=%0d od=0x%0h", occupancy, out_data);
    check("fill_occupancy", {30'b0, occupancy}, 32'd2);
    check("fill_out_data", out_data, 32'h21);
    reset_pulse();

    // Single-entry variant: in_ready follows out_ready combinationally.
    @(negedge CLK); drive(1, 32'h31, 0, 0, 0, 0);
    @(posedge CLK); #1;
    @(negedge CLK); drive(0, 32'h0, 0, 0, 0, 0);
    #1;
    $display("single-entry: occ0=%0d od0=0x%0h ir0=%0b (out_ready=0)", occupancy_0, out_data_0, in_ready_0);
    check("single_occupancy", {30'b0, occupancy_0}, 32'd1);
    check("single_out_data", out_data_0, 32'h31);
    check("single_in_ready_blocked", {31'b0, in_ready_0}, 32'd0);
    out_ready = 1'b1;
    #1;
    $display("single-entry: ir0=%0b (out_ready=1)", in_ready_0);
    check("single_in_ready_pass", {31'b0, in_ready_0}, 32'd1);
    @(posedge CLK); #1;
    check("single_drained_valid", {31'b0, out_valid_0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
